// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller and
// anything else that needs to interpret the board (display, judge).
package ttt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PLACE,
    S_JUDGE,
    S_OVER
  } state_t;

  typedef enum logic [1:0] {
    RES_RUN  = 2'b00,
    RES_X    = 2'b01,
    RES_O    = 2'b10,
    RES_DRAW = 2'b11
  } res_t;

  localparam int NUM_LINES = 8;

  // Occupancy masks, bit k-1 = cell k: three rows, three columns, two diagonals.
  localparam logic [8:0] LINE_MASK [NUM_LINES] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  // Board bit index for cell k (1..9): O lives at 19-2k, X at 18-2k.
  function automatic logic [4:0] cell_bit(input logic [3:0] k, input logic is_o);
    logic [4:0] k2;
    k2 = {k, 1'b0};
    return is_o ? (5'd19 - k2) : (5'd18 - k2);
  endfunction

endpackage

// File: rtl/ttt_turn_ctrl_if.sv
// Keypad-side inputs and board/status outputs of the turn controller.
// master = keypad/menu/display side, slave = the controller itself.
interface ttt_turn_ctrl_if;
  logic [3:0]  key_data;
  logic        is_main;
  logic [17:0] board;
  logic        is_turn_o;
  logic [1:0]  result;
  logic [3:0]  move_count;
  logic        illegal;
  logic        busy;

  modport master (
    output key_data, is_main,
    input  board, is_turn_o, result, move_count, illegal, busy
  );

  modport slave (
    input  key_data, is_main,
    output board, is_turn_o, result, move_count, illegal, busy
  );
endinterface

// File: rtl/ttt_line_judge.sv
// Combinational line check for one player's 9-bit occupancy.
// win_o: any row/column/diagonal complete; full_o: all nine cells held.
module ttt_line_judge
  import ttt_pkg::*;
(
  input  logic [8:0] occ_i,
  output logic       win_o,
  output logic       full_o
);

  // OR of all eight complete-line tests
  always_comb begin
    win_o = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if ((occ_i & LINE_MASK[i]) == LINE_MASK[i]) win_o = 1'b1;
    end
  end

  assign full_o = &occ_i;

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe turn sequencer: synchronises keypad codes, validates moves,
// writes the board, judges the mover and alternates turns, with an
// optional per-move timeout.
module ttt_turn_ctrl
  import ttt_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FIRST_O        = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  ttt_turn_ctrl_if.slave  bus
);

  localparam int            TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT_CYCLES);
  localparam logic          TURN_INIT = (FIRST_O != 0);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]    key_s, key_prev_q;
  logic          press, key_ok, tmo_hit;
  state_t        state_q, state_d;
  logic [17:0]   board_q, board_d;
  logic          turn_q, turn_d;
  res_t          res_q, res_d;
  logic [3:0]    mc_q, mc_d, cell_q, cell_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          ill_q, ill_d;
  logic [8:0]    occ_x, occ_o, occ_all, occ_mv;
  logic          mv_win, mv_full;

  // Keypad synchroniser chain plus previous-key register for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      key_prev_q <= '0;
    end else begin
      sync_q[0] <= bus.key_data;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      key_prev_q <= key_s;
    end
  end

  assign key_s = sync_q[SYNC_STAGES-1];
  // Only a 0 -> nonzero transition counts; holding or rolling keys does not.
  assign press = (key_s != 4'd0) && (key_prev_q == 4'd0);

  for (genvar k = 1; k <= 9; k++) begin : g_occ
    assign occ_x[k-1] = board_q[18-2*k];
    assign occ_o[k-1] = board_q[19-2*k];
  end

  assign occ_all = occ_x | occ_o;
  assign occ_mv  = turn_q ? occ_o : occ_x;
  assign key_ok  = (key_s >= 4'd1) && (key_s <= 4'd9) && !occ_all[key_s - 4'd1];
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmr_q == TW'(1));

  ttt_line_judge u_judge (
    .occ_i  (occ_mv),
    .win_o  (mv_win),
    .full_o (mv_full)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      board_q <= '0;
      turn_q  <= TURN_INIT;
      res_q   <= RES_RUN;
      mc_q    <= '0;
      cell_q  <= '0;
      tmr_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      turn_q  <= turn_d;
      res_q   <= res_d;
      mc_q    <= mc_d;
      cell_q  <= cell_d;
      tmr_q   <= tmr_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state and datapath updates; menu abort overrides everything below it
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    turn_d  = turn_q;
    res_d   = res_q;
    mc_d    = mc_q;
    cell_d  = cell_q;
    tmr_d   = tmr_q;
    ill_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        board_d = '0;
        res_d   = RES_RUN;
        mc_d    = '0;
        turn_d  = TURN_INIT;
        if (!bus.is_main) begin
          state_d = S_WAIT;
          tmr_d   = TMR_LOAD;
        end
      end
      S_WAIT: begin
        tmr_d = tmr_q - TW'(1);
        if (press && key_ok) begin
          // A valid move on the expiry cycle beats the timeout.
          cell_d  = key_s;
          state_d = S_PLACE;
        end else begin
          if (press) ill_d = 1'b1;
          if (tmo_hit) begin
            res_d   = turn_q ? RES_X : RES_O;
            state_d = S_OVER;
          end
        end
      end
      S_PLACE: begin
        board_d[cell_bit(cell_q, turn_q)] = 1'b1;
        mc_d    = mc_q + 4'd1;
        state_d = S_JUDGE;
      end
      S_JUDGE: begin
        // A full mover mask always contains a line; folding it in is harmless
        // and keeps the judge's full flag meaningful here.
        if (mv_win || mv_full) begin
          res_d   = turn_q ? RES_O : RES_X;
          state_d = S_OVER;
        end else if (mc_q == 4'd9) begin
          res_d   = RES_DRAW;
          state_d = S_OVER;
        end else begin
          turn_d  = ~turn_q;
          tmr_d   = TMR_LOAD;
          state_d = S_WAIT;
        end
      end
      S_OVER: ;
      default: state_d = S_IDLE;
    endcase
    if (bus.is_main && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      board_d = '0;
      res_d   = RES_RUN;
      mc_d    = '0;
      turn_d  = TURN_INIT;
      ill_d   = 1'b0;
    end
  end

  assign bus.board      = board_q;
  assign bus.is_turn_o  = turn_q;
  assign bus.result     = res_q;
  assign bus.move_count = mc_q;
  assign bus.illegal    = ill_q;
  assign bus.busy       = (state_q == S_PLACE) || (state_q == S_JUDGE);

endmodule

// File: doc/ttt_turn_ctrl.md
Name: ttt_turn_ctrl

Overview:
- Sequencer for the tic-tac-toe game datapath. It owns the 18-bit board register, the turn flag and the result code.
- It turns raw keypad codes into validated moves, writes one cell per move, judges the board after each write and alternates players.
- It sits between the keypad decoder and the display/segment logic. Those blocks only read board, is_turn_o and result.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on key_data before edge detection (min 1).
- FIRST_O, 0: 1 means O moves first after a game starts; 0 means X (P1) moves first.
- TIMEOUT_CYCLES, 0: cycles allowed per move. 0 disables the timeout. Counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_data  in  4  raw keypad code; 0 = no key, 1..9 = cell, 10..15 = non-cell keys
- is_main  in  1  1 = main menu shown; forces the block to idle
- board  out  18  cell k (1..9): bit 19-2k = O, bit 18-2k = X
- is_turn_o  out  1  1 = O to move
- result  out  2  00 in progress, 01 X wins, 10 O wins, 11 draw
- move_count  out  4  number of cells filled, 0..9
- illegal  out  1  one-cycle pulse when a key press is rejected
- busy  out  1  high in PLACE and JUDGE

Behaviour:
- Reset (async, rst=1):
  - board=0, result=00, move_count=0, illegal=0, busy=0.
  - is_turn_o=FIRST_O, state=IDLE.
  - Synchronizer and previous-key registers cleared to 0.
- Key path:
  - key_data passes through SYNC_STAGES flops to give key_s.
  - A press is the cycle where key_s != 0 and key_prev == 0; key_prev <= key_s every cycle.
  - Holding a key generates exactly one press. A code change without returning to 0 generates no press.
- State IDLE:
  - board=0, result=00, move_count=0, is_turn_o=FIRST_O.
  - When is_main=0, go to WAIT on the next edge and load the timeout counter.
- State WAIT, on a press with code c:
  - c in 10..15 or cell c occupied (either bit set): illegal=1 for one cycle, stay in WAIT, timer keeps running.
  - Otherwise latch c into cell_r and go to PLACE.
  - Presses in any other state are ignored; no illegal pulse.
- State PLACE:
  - Set board bit 19-2c if is_turn_o=1, else bit 18-2c.
  - move_count += 1. Go to JUDGE.
- State JUDGE: test the 8 lines (rows, columns, two diagonals) for the mover only.
  - Mover has a line: result=10 if the mover is O, 01 if X; go to OVER. Win takes priority over full board.
  - Else move_count==9: result=11, go to OVER.
  - Else toggle is_turn_o, reload the timer, go to WAIT.
- State OVER:
  - board, result and is_turn_o held.
  - is_main=1 goes to IDLE.
- Latency:
  - Press seen in WAIT at cycle N.
  - Board and move_count updated and visible at cycle N+2.
  - Result or turn toggle visible at cycle N+3.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter decrements in WAIT only.
  - On reaching 0, the opponent wins: result=01 if is_turn_o=1, else 10. Go to OVER.
  - A valid press on the same cycle as expiry wins over the timeout.
- is_main=1 in any state except IDLE:
  - Abort to IDLE on the next edge.
  - board and result are cleared in IDLE.
  - The abort overrides any pending PLACE or JUDGE.
- rst mid-game: immediate return to the reset values, regardless of state.

Decomposition:
- Package ttt_pkg:
  - state encoding: IDLE, WAIT, PLACE, JUDGE, OVER
  - result codes: RES_RUN, RES_X, RES_O, RES_DRAW
  - 8 constant 9-bit line masks
  - function cell_bit(k, is_o)
- Sub-module ttt_line_judge (combinational):
  - Inputs: 9-bit occupancy of one player.
  - Outputs: win flag and full flag.
  - One instance in the controller; it is reusable by the display block.

Test Plan:
- rst=1 then release with is_main=1 -> board=0, result=00, is_turn_o=0, state IDLE. Drop is_main -> WAIT.
- X wins, X1 O4 X2 O5 X3 (key released between presses) -> board=18'h15A00, result=01 three cycles after the 5th press, move_count=5, later presses ignored.
- Press 1 (X), then 1 again -> one-cycle illegal pulse, board unchanged, is_turn_o stays 1. Key 12 -> illegal pulse.
- Draw, X1 O2 X3 O5 X4 O6 X8 O7 X9 -> result=11, move_count=9, no earlier win.
- Mid-game, after 3 moves raise is_main for one cycle -> next edge IDLE, board=0, result=00, move_count=0.
- TIMEOUT_CYCLES=16, no press after start -> result=10 (O wins, X timed out) after the 16th WAIT cycle. A press on the same expiry cycle is accepted instead.
